// File: rtl/fpm_pkg.sv
`default_nettype none
// ============================================================================
// fpm_pkg : shared types, flag indices and width helpers for fpm_pipe
// Rev 1.0
// ============================================================================
package fpm_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fpm_class_e;

  localparam int c_flg_inexact   = 0;
  localparam int c_flg_underflow = 1;
  localparam int c_flg_overflow  = 2;
  localparam int c_flg_invalid   = 3;

  function automatic int fpm_word_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int fpm_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Quiet NaN with sign 0, exponent all-ones and only the fraction MSB set.
  function automatic logic [63:0] fpm_qnan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpm_round_pack.sv
`default_nettype none
// ============================================================================
// fpm_round_pack : final-stage normalise, RNE round, range check and pack
// Rev 1.0
// ============================================================================
module fpm_round_pack
  import fpm_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 i_sign,
  input  fpm_class_e           i_cls,
  input  logic                 i_invalid,
  input  logic [EXP_W+1:0]     i_exp_sum,
  input  logic [2*MAN_W+1:0]   i_prod,
  output logic [EXP_W+MAN_W:0] o_p,
  output logic                 o_zero,
  output logic [3:0]           o_flags
);

  localparam logic [EXP_W+MAN_W:0] c_qnan = (EXP_W+MAN_W+1)'(fpm_qnan(EXP_W, MAN_W));
  localparam logic [EXP_W+1:0]     c_emax = {2'b00, {EXP_W{1'b1}}};

  logic             w_hi, w_guard, w_sticky, w_up, w_carry, w_inexact, w_ovf, w_unf;
  logic [MAN_W-1:0] w_frac, w_frac_r;
  logic [EXP_W+1:0] w_exp_f;

  // Exponent is carried as a two's-complement value two bits wider than the field.
  always_comb begin
    w_hi = i_prod[2*MAN_W+1];
    if (w_hi) begin
      w_frac   = i_prod[2*MAN_W:MAN_W+1];
      w_guard  = i_prod[MAN_W];
      w_sticky = |i_prod[MAN_W-1:0];
    end else begin
      w_frac   = i_prod[2*MAN_W-1:MAN_W];
      w_guard  = i_prod[MAN_W-1];
      w_sticky = |i_prod[MAN_W-2:0];
    end
    w_up                = w_guard & (w_sticky | w_frac[0]);
    {w_carry, w_frac_r} = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_up};
    w_exp_f   = i_exp_sum + {{(EXP_W+1){1'b0}}, w_hi} + {{(EXP_W+1){1'b0}}, w_carry};
    w_inexact = w_guard | w_sticky;
    w_ovf     = !w_exp_f[EXP_W+1] && (w_exp_f >= c_emax);
    w_unf     = w_exp_f[EXP_W+1] || (w_exp_f == '0);
  end

  always_comb begin
    o_p     = '0;
    o_zero  = 1'b0;
    o_flags = '0;
    case (i_cls)
      CLS_NAN: begin
        o_p                   = c_qnan;
        o_flags[c_flg_invalid] = i_invalid;
      end
      CLS_INF:  o_p = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: begin
        o_p    = {i_sign, {(EXP_W+MAN_W){1'b0}}};
        o_zero = 1'b1;
      end
      default: begin
        if (w_ovf) begin
          o_p                     = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          o_flags[c_flg_overflow] = 1'b1;
          o_flags[c_flg_inexact]  = 1'b1;
        end else if (w_unf) begin
          o_p                      = {i_sign, {(EXP_W+MAN_W){1'b0}}};
          o_zero                   = 1'b1;
          o_flags[c_flg_underflow] = 1'b1;
          o_flags[c_flg_inexact]   = 1'b1;
        end else begin
          o_p                    = {i_sign, w_exp_f[EXP_W-1:0], w_frac_r};
          o_flags[c_flg_inexact] = w_inexact;
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fpm_pipe.sv
`default_nettype none
// ============================================================================
// fpm_pipe : 3-stage parametrised FP multiplier with valid/ready backpressure
// Rev 1.0
// ============================================================================
module fpm_pipe
  import fpm_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic                 in_zero_a,
  input  logic                 in_zero_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_p,
  output logic                 out_zero,
  output logic [3:0]           out_flags
);

  localparam int               W      = fpm_word_w(EXP_W, MAN_W);
  localparam logic [EXP_W+1:0] c_bias = (EXP_W+2)'(fpm_bias(EXP_W));

  function automatic fpm_class_e classify(input logic zero_sb, input logic [W-1:0] x);
    if (zero_sb || x[W-2:MAN_W] == '0) return CLS_ZERO;
    if (&x[W-2:MAN_W]) return (x[MAN_W-1:0] == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  logic w_en;
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  logic             r1_valid, r1_sign;
  fpm_class_e       r1_cls_a, r1_cls_b;
  logic [EXP_W-1:0] r1_exp_a, r1_exp_b;
  logic [MAN_W:0]   r1_man_a, r1_man_b;

  logic               r2_valid, r2_sign, r2_invalid;
  fpm_class_e         r2_cls;
  logic [EXP_W+1:0]   r2_exp_sum;
  logic [2*MAN_W+1:0] r2_prod;

  fpm_class_e         w_cls;
  logic               w_invalid;
  logic [EXP_W+1:0]   w_exp_sum;
  logic [2*MAN_W+1:0] w_prod;

  // Special-result precedence: NaN (incl. Inf*Zero), then Inf, then Zero.
  always_comb begin
    w_invalid = (r1_cls_a == CLS_INF && r1_cls_b == CLS_ZERO) ||
                (r1_cls_a == CLS_ZERO && r1_cls_b == CLS_INF);
    if (w_invalid || r1_cls_a == CLS_NAN || r1_cls_b == CLS_NAN)  w_cls = CLS_NAN;
    else if (r1_cls_a == CLS_INF || r1_cls_b == CLS_INF)          w_cls = CLS_INF;
    else if (r1_cls_a == CLS_ZERO || r1_cls_b == CLS_ZERO)        w_cls = CLS_ZERO;
    else                                                          w_cls = CLS_NORM;
    w_exp_sum = {2'b00, r1_exp_a} + {2'b00, r1_exp_b} - c_bias;
    w_prod    = {{(MAN_W+1){1'b0}}, r1_man_a} * {{(MAN_W+1){1'b0}}, r1_man_b};
  end

  logic [W-1:0] w_p;
  logic         w_zero;
  logic [3:0]   w_flags;

  fpm_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .i_sign    (r2_sign),
    .i_cls     (r2_cls),
    .i_invalid (r2_invalid),
    .i_exp_sum (r2_exp_sum),
    .i_prod    (r2_prod),
    .o_p       (w_p),
    .o_zero    (w_zero),
    .o_flags   (w_flags)
  );

  always_ff @(posedge clk) begin
    if (w_en) begin
      r1_sign    <= in_a[W-1] ^ in_b[W-1];
      r1_cls_a   <= classify(in_zero_a, in_a);
      r1_cls_b   <= classify(in_zero_b, in_b);
      r1_exp_a   <= in_a[W-2:MAN_W];
      r1_exp_b   <= in_b[W-2:MAN_W];
      r1_man_a   <= {1'b1, in_a[MAN_W-1:0]};
      r1_man_b   <= {1'b1, in_b[MAN_W-1:0]};
      r2_sign    <= r1_sign;
      r2_cls     <= w_cls;
      r2_invalid <= w_invalid;
      r2_exp_sum <= w_exp_sum;
      r2_prod    <= w_prod;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r1_valid  <= 1'b0;
      r2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_zero  <= 1'b0;
      out_flags <= '0;
    end else if (w_en) begin
      r1_valid  <= in_valid;
      r2_valid  <= r1_valid;
      out_valid <= r2_valid;
      if (r2_valid) begin
        out_p     <= w_p;
        out_zero  <= w_zero;
        out_flags <= w_flags;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpm_pipe.sv
`default_nettype none
// ============================================================================
// tb_fpm_pipe : directed self-checking bench for fpm_pipe (E8M23 and E5M10)
// Rev 1.0
// ============================================================================
module tb_fpm_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, in_zero_a, in_zero_b;
  logic [31:0] in_a, in_b, out_p;
  logic        out_valid, out_ready, out_zero;
  logic [3:0]  out_flags;

  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_out_zero;
  logic [15:0] h_in_a, h_in_b, h_out_p;
  logic [3:0]  h_out_flags;

  int n_checks = 0;
  int n_fail   = 0;

  fpm_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_zero_a(in_zero_a), .in_zero_b(in_zero_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_zero(out_zero), .out_flags(out_flags)
  );

  fpm_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst),
    .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_a(h_in_a), .in_b(h_in_b), .in_zero_a(1'b0), .in_zero_b(1'b0),
    .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out_p(h_out_p), .out_zero(h_out_zero), .out_flags(h_out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One isolated operation with out_ready held high; latency counts the accept edge.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic za, input logic zb,
                        input logic [31:0] ep, input logic ez, input logic [3:0] ef);
    int lat;
    @(negedge clk);
    in_a = a; in_b = b; in_zero_a = za; in_zero_b = zb; in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid = 1'b0; in_zero_a = 1'b0; in_zero_b = 1'b0;
    end while (!out_valid && lat < 10);
    check_eq({tag, "_lat"},   lat, 3);
    check_eq({tag, "_p"},     out_p, ep);
    check_eq({tag, "_zero"},  {31'd0, out_zero}, {31'd0, ez});
    check_eq({tag, "_flags"}, {28'd0, out_flags}, {28'd0, ef});
  endtask

  logic [31:0] sb   [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] sexp [8] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                            32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};
  logic [3:0]  rdy_pat = 4'b1001;

  initial begin
    int tx, rx, cyc, extra, lat;
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_zero_a = 1'b0; in_zero_b = 1'b0;
    out_ready = 1'b1;
    h_in_valid = 1'b0; h_in_a = '0; h_in_b = '0; h_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_p",     out_p, 32'd0);
    check_eq("rst_flags", {28'd0, out_flags}, 32'd0);
    check_eq("rst_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;

    run_op("mul2x3",   32'h40000000, 32'h40400000, 1'b0, 1'b0, 32'h40C00000, 1'b0, 4'b0000);
    run_op("mul15sq",  32'h3FC00000, 32'h3FC00000, 1'b0, 1'b0, 32'h40100000, 1'b0, 4'b0000);
    run_op("rne",      32'h3F800001, 32'h3F800001, 1'b0, 1'b0, 32'h3F800002, 1'b0, 4'b0001);
    run_op("ovf",      32'h7F000000, 32'h7F000000, 1'b0, 1'b0, 32'h7F800000, 1'b0, 4'b0101);
    run_op("unf",      32'h00800000, 32'h00800000, 1'b0, 1'b0, 32'h00000000, 1'b1, 4'b0011);
    run_op("infx0",    32'h7F800000, 32'h00000000, 1'b0, 1'b0, 32'h7FC00000, 1'b0, 4'b1000);
    run_op("negzero",  32'h80000000, 32'h40000000, 1'b0, 1'b0, 32'h80000000, 1'b1, 4'b0000);
    run_op("sbzero",   32'h40400000, 32'hC0000000, 1'b1, 1'b0, 32'h80000000, 1'b1, 4'b0000);
    run_op("nanop",    32'h7F800001, 32'h3F800000, 1'b0, 1'b0, 32'h7FC00000, 1'b0, 4'b0000);
    run_op("infneg",   32'h7F800000, 32'hC0000000, 1'b0, 1'b0, 32'hFF800000, 1'b0, 4'b0000);

    // Streaming with backpressure: every visible result must be the next expected one.
    tx = 0; rx = 0; cyc = 0;
    while (rx < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = rdy_pat[cyc % 4];
      if (out_valid) begin
        check_eq($sformatf("stream_p%0d", rx), out_p, sexp[rx]);
        if (out_ready) rx++;
      end
      if (tx < 8) begin
        in_valid = 1'b1; in_a = 32'h40000000; in_b = sb[tx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) tx++;
      cyc++;
    end
    check_eq("stream_count", rx, 8);
    in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check_eq("stream_no_dup", extra, 0);

    // Load three ops under a stall, then reset with them in flight.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 32'h40000000; in_b = 32'h40400000;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check_eq("rst_preload_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_eq("midrst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("midrst_p",     out_p, 32'd0);
    check_eq("midrst_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check_eq("midrst_no_stale", extra, 0);

    // Half-precision-like instance.
    @(negedge clk);
    h_in_valid = 1'b1; h_in_a = 16'h4000; h_in_b = 16'h4200;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      h_in_valid = 1'b0;
    end while (!h_out_valid && lat < 10);
    check_eq("h_lat",   lat, 3);
    check_eq("h_p",     {16'd0, h_out_p}, 32'h00004600);
    check_eq("h_flags", {28'd0, h_out_flags}, 32'd0);
    check_eq("h_zero",  {31'd0, h_out_zero}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
